// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data memory responder.
// The CLEAR state exists only when DMEM_RESET_CLEAR_EN is defined.
package dmem_pkg;

    localparam int ADDR_W      = 6;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 64;
    localparam int LATENCY_DEF = 5;
    localparam int CNT_W       = 4;

`ifdef DMEM_RESET_CLEAR_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE, CLEAR} state_e;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
`endif

endpackage

// File: rtl/dmem_array.sv
// 64x32 block storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; clearing is done by the responder's sweep.
module dmem_array
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency block memory responder for a cache controller (busywait handshake).
// Define DMEM_RESET_CLEAR_EN to zero all 64 blocks after every reset release.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_op_q, wr_op_d;

    logic              req;
    logic              accept;
    logic              commit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_RESET_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

    // Exactly one of read/write forms a request; both high is ignored.
    assign req = read ^ write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef DMEM_RESET_CLEAR_EN
            state_q    <= CLEAR;
            clr_addr_q <= '0;
`else
            state_q    <= IDLE;
`endif
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
`ifdef DMEM_RESET_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wr_op_q <= wr_op_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef DMEM_RESET_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
`ifdef DMEM_RESET_CLEAR_EN
            CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busywait  = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                busywait = req;
                accept   = req;
            end
            BUSY: begin
                busywait = 1'b1;
                commit   = (cnt_q == '0);
                mem_we   = (cnt_q == '0) && wr_op_q;
            end
`ifdef DMEM_RESET_CLEAR_EN
            CLEAR: begin
                busywait  = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
            end
`endif
            default: begin
                busywait = 1'b0;
            end
        endcase
    end

    // Latched request is frozen for the whole access so later input changes are ignored.
    assign addr_d     = accept ? address   : addr_q;
    assign wdata_d    = accept ? writedata : wdata_q;
    assign wr_op_d    = accept ? write     : wr_op_q;
    assign readdata_d = (commit && !wr_op_q) ? mem_rdata : readdata_q;
    assign readdata   = readdata_q;

    dmem_array u_array (
        .clk     (clk),
        .we_i    (mem_we && !reset),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (addr_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 5, SHALL set the number of clock cycles busywait is high per accepted access (legal range 2..15).
REQ-002 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 read  input  1  block read request from the cache controller.
REQ-005 write  input  1  block write request from the cache controller.
REQ-006 address  input  6  block address, i.e. {tag, index}; 64 blocks of 32 bits.
REQ-007 writedata  input  32  block data to store on write.
REQ-008 readdata  output  32  block data returned on read.
REQ-009 busywait  output  1  high while an access is in progress; the requester holds its request until it sees busywait low.

Function
REQ-010 The FSM SHALL have states IDLE, BUSY and DONE, plus CLEAR when REQ-024 is compiled in.
REQ-011 A request (read XOR write high) in IDLE SHALL drive busywait high combinationally in that same cycle, latch address, writedata and the op, load the counter with LATENCY-2, and enter BUSY at the next edge.
REQ-012 In BUSY, busywait SHALL be high; the counter SHALL decrement each edge; at the edge where the counter is 0, the access SHALL commit and the FSM SHALL enter DONE.
REQ-013 busywait SHALL be high for exactly LATENCY consecutive cycles per access, counted from the cycle the request is first seen.
REQ-014 Read commit: readdata SHALL be loaded from mem[latched address] and held until the next read commit or reset.
REQ-015 Write commit: mem[latched address] SHALL be written with the latched writedata; readdata SHALL be unchanged.
REQ-016 DONE SHALL last one cycle with busywait low, ignore read/write (the requester drops its request during this cycle), then return to IDLE.
REQ-017 Inputs changing during BUSY SHALL have no effect; the latched values are used.
REQ-018 read and write both high in IDLE SHALL be ignored: no access, busywait low, FSM stays in IDLE.
REQ-019 A read that follows a write to the same block SHALL return the newly written data.

Reset
REQ-020 Reset SHALL force the FSM to IDLE (or CLEAR, per REQ-024), counter=0, readdata=32'h0, and busywait low (except in CLEAR).
REQ-021 Reset asserted during BUSY SHALL abort the access with no array write.
REQ-022 Array contents SHALL NOT be altered by reset, except as given in REQ-024.

Configuration
REQ-023 Macro DMEM_RESET_CLEAR_EN SHALL select the clear-on-reset feature.
REQ-024 When DMEM_RESET_CLEAR_EN is defined, reset release SHALL enter CLEAR, zero blocks 0..63 one per cycle (64 cycles) with busywait high and requests ignored, then enter IDLE.
REQ-025 When DMEM_RESET_CLEAR_EN is undefined, the CLEAR state SHALL not exist and reset release SHALL enter IDLE directly.

Structure
REQ-026 Package dmem_pkg SHALL hold the state encoding, the constants ADDR_W=6, DATA_W=32 and DEPTH=64, and the LATENCY default.
REQ-027 Storage SHALL be a sub-module dmem_array: 64x32, one synchronous write port and one read port.
REQ-028 The FSM, the counter and the CLEAR sweep SHALL reside in data_mem_responder.

Verification
REQ-029 Write 32'hDEADBEEF to address 6'h05, then read 6'h05 -> busywait high 5 cycles for each access, and readdata=32'hDEADBEEF in the DONE cycle.
REQ-030 Read request held high through DONE -> exactly one access and no restart; busywait low in DONE.
REQ-031 read=write=1 in IDLE for 3 cycles -> busywait stays 0, the array is unchanged, and readdata is unchanged.
REQ-032 Reset pulse at the 3rd BUSY cycle of a write of 32'h12345678 to 6'h3F -> a later read of 6'h3F does not return 32'h12345678; readdata=0 right after reset.
REQ-033 With DMEM_RESET_CLEAR_EN: reset release -> busywait high 64 cycles, then reads of 6'h00 and 6'h3F return 32'h0.
REQ-034 Run with LATENCY=2 and LATENCY=15 -> busywait width equals LATENCY for both read and write.
